masked_max_scan: RTL
====================

MASKED_MAX_SCAN -- requirements
Module: masked_max_scan

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each candidate value.
REQ-002 Parameter NUM, default 8: number of candidate channels, allowed range 2..256.
REQ-003 Parameter IDX_BITS, default 3: index width, SHALL satisfy 2**IDX_BITS >= NUM.
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active low.
REQ-006 start  input  1  request a new scan; single-cycle strobe.
REQ-007 abort  input  1  cancel the scan in progress.
REQ-008 values  input  NUM*WIDTH  candidate values; channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-009 masks  input  NUM  per-channel valid mask; 1 means the channel participates.
REQ-010 busy  output  1  scan in progress.
REQ-011 done  output  1  one-cycle pulse; result is updated.
REQ-012 max  output  WIDTH  largest unmasked value.
REQ-013 index  output  IDX_BITS  channel number of max.
REQ-014 valid  output  1  at least one channel was unmasked in the completed scan.

Function
REQ-015 The block SHALL implement three states: IDLE, SCAN and DONE.
REQ-016 In IDLE or DONE, start=1 with abort=0 at edge E0 SHALL snapshot values and masks into internal registers, clear the channel counter to 0, clear the running valid flag, and enter SCAN.
REQ-017 Changes on values and masks after E0 SHALL NOT affect the scan in progress.
REQ-018 In SCAN, edge Ek (k=1..NUM) SHALL evaluate channel k-1 against the running maximum.
REQ-019 Each evaluation SHALL take the channel when mask=1 and either (a) the running valid flag is 0, or (b) the channel value is strictly greater (unsigned) than the running maximum.
REQ-020 Equal values SHALL NOT replace the running maximum, so the lowest index wins ties.
REQ-021 A channel that is taken SHALL load the running maximum and running index with that channel and set the running valid flag.
REQ-022 At edge E_NUM, after the last channel is evaluated, the block SHALL enter DONE and load max, index and valid from the final running values.
REQ-023 If no channel was unmasked, the block SHALL output max=0, index=0 and valid=0.
REQ-024 done SHALL be 1 for exactly the one cycle spent in DONE, i.e. after E_NUM.
REQ-025 The block SHALL return to IDLE at E_NUM+1 unless start is accepted at that edge (back-to-back scan per REQ-016).
REQ-026 Total latency SHALL be: start sampled at E0, done high in the cycle following E_NUM, which is NUM+1 edges after E0.
REQ-027 busy SHALL be 1 exactly while in SCAN, i.e. after E0 through E_NUM; busy and done SHALL never both be 1.
REQ-028 start received while in SCAN SHALL be ignored, with no queuing.
REQ-029 abort=1 in SCAN SHALL return the block to IDLE on that edge, with no done pulse, and max, index and valid SHALL keep their previous values.
REQ-030 abort=1 with start=1 in IDLE or DONE SHALL be resolved as: abort wins, start is ignored, next state is IDLE.
REQ-031 abort=1 in DONE SHALL NOT suppress the done pulse already being output.
REQ-032 Outputs max, index and valid SHALL hold their values between scans and change only at E_NUM of a completed scan.
REQ-033 The channel counter SHALL be IDX_BITS+1 bits wide or otherwise shall not wrap before NUM channels are evaluated when NUM = 2**IDX_BITS.
REQ-034 The comparison and update per channel SHALL complete within one clock; no multicycle paths are allowed.

Reset
REQ-035 rst_n=0 SHALL asynchronously force: state IDLE, busy=0, done=0, max=0, index=0, valid=0, counter=0, running registers cleared.
REQ-036 rst_n asserted mid-scan SHALL discard the scan; no done pulse SHALL follow the reset release.
REQ-037 After rst_n is deasserted, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-038 Single scan (NUM=8): values={10,50,30,50,0,0,0,7}, masks=8'hFF, start pulse -> done 9 edges later, max=50, index=1, valid=1; busy high for 8 cycles.
REQ-039 Masked peak: same values, masks=8'b11111101 -> max=50, index=3, valid=1. All masked, masks=0 -> max=0, index=0, valid=0, done still pulses.
REQ-040 Snapshot and ignore: values are changed and start is pulsed during SCAN -> result reflects the E0 snapshot only, and exactly one done pulse occurs.
REQ-041 Abort: abort is asserted at E4 of a scan whose previous result was max=50, index=1 -> no done pulse, outputs remain 50/1/1, and the next start works normally.
REQ-042 Back-to-back: start is held high in the DONE cycle -> a second scan begins without an IDLE cycle, and done pulses are spaced exactly NUM+1 cycles apart.
REQ-043 Reset mid-scan: rst_n is pulled low between clock edges at E5 -> all outputs go to 0 immediately, and no done pulse occurs after release.

Source files
------------

// File: rtl/masked_max_scan.sv
`default_nettype none
// ============================================================================
//  Module   : masked_max_scan
//  Purpose  : Sequential arg-max over NUM masked candidate channels. A start
//             strobe snapshots the candidate values and masks, then one
//             channel is evaluated per clock. The largest unmasked value and
//             its channel number are published together with a one-cycle
//             done pulse. On ties the lowest channel index wins.
//  Ports    : clk    - clock; all state updates on the rising edge
//             rst_n  - asynchronous reset, active low
//             start  - single-cycle request for a new scan
//             abort  - cancel the scan in progress (wins over start)
//             values - NUM packed candidates, channel i at [i*WIDTH +: WIDTH]
//             masks  - per-channel participate flag (1 = participates)
//             busy   - scan in progress
//             done   - one-cycle pulse, result outputs just updated
//             max    - largest unmasked value of the last completed scan
//             index  - channel number of max
//             valid  - at least one channel was unmasked in that scan
//  Revision : 1.0 - initial release
// ============================================================================
module masked_max_scan #(
  parameter int WIDTH    = 16,
  parameter int NUM      = 8,
  parameter int IDX_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM*WIDTH-1:0]    values,
  input  logic [NUM-1:0]          masks,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        max,
  output logic [IDX_BITS-1:0]     index,
  output logic                    valid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter is one bit wider than the index so that NUM == 2**IDX_BITS
  // never wraps before the last channel has been evaluated.
  localparam logic [IDX_BITS:0] LAST_CH = (IDX_BITS + 1)'(NUM - 1);

  state_e                 state_q,     state_d;
  logic [NUM*WIDTH-1:0]   vals_q,      vals_d;
  logic [NUM-1:0]         msk_q,       msk_d;
  logic [IDX_BITS:0]      cnt_q,       cnt_d;
  logic [WIDTH-1:0]       run_max_q,   run_max_d;
  logic [IDX_BITS-1:0]    run_idx_q,   run_idx_d;
  logic                   run_valid_q, run_valid_d;
  logic [WIDTH-1:0]       max_q,       max_d;
  logic [IDX_BITS-1:0]    index_q,     index_d;
  logic                   valid_q,     valid_d;

  // Channel currently under evaluation and its running-result update.
  logic [WIDTH-1:0]       ch_val;
  logic                   ch_mask;
  logic                   take;
  logic [WIDTH-1:0]       nxt_max;
  logic [IDX_BITS-1:0]    nxt_idx;
  logic                   nxt_valid;

  always_comb begin
    ch_val  = '0;
    ch_mask = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (cnt_q == (IDX_BITS + 1)'(i)) begin
        ch_val  = vals_q[i*WIDTH +: WIDTH];
        ch_mask = msk_q[i];
      end
    end

    // Strictly greater: an equal later channel never displaces an earlier one.
    take      = ch_mask && (!run_valid_q || (ch_val > run_max_q));
    nxt_max   = take ? ch_val : run_max_q;
    nxt_idx   = take ? cnt_q[IDX_BITS-1:0] : run_idx_q;
    nxt_valid = run_valid_q | take;
  end

  always_comb begin
    state_d     = state_q;
    vals_d      = vals_q;
    msk_d       = msk_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    run_valid_d = run_valid_q;
    max_d       = max_q;
    index_d     = index_q;
    valid_d     = valid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Abort beats start; DONE always leaves after its single cycle.
        state_d = ST_IDLE;
        if (!abort && start) begin
          state_d     = ST_SCAN;
          vals_d      = values;
          msk_d       = masks;
          cnt_d       = '0;
          run_max_d   = '0;
          run_idx_d   = '0;
          run_valid_d = 1'b0;
        end
      end

      ST_SCAN: begin
        if (abort) begin
          // Published result is left untouched on cancel.
          state_d = ST_IDLE;
        end else begin
          run_max_d   = nxt_max;
          run_idx_d   = nxt_idx;
          run_valid_d = nxt_valid;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_CH) begin
            state_d = ST_DONE;
            valid_d = nxt_valid;
            // An all-masked scan reports zeros rather than stale running data.
            max_d   = nxt_valid ? nxt_max : '0;
            index_d = nxt_valid ? nxt_idx : '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vals_q      <= '0;
      msk_q       <= '0;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      run_valid_q <= 1'b0;
      max_q       <= '0;
      index_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      vals_q      <= vals_d;
      msk_q       <= msk_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      run_valid_q <= run_valid_d;
      max_q       <= max_d;
      index_q     <= index_d;
      valid_q     <= valid_d;
    end
  end

  assign busy  = (state_q == ST_SCAN);
  assign done  = (state_q == ST_DONE);
  assign max   = max_q;
  assign index = index_q;
  assign valid = valid_q;

endmodule
`default_nettype wire
